// File: rtl/ft232h_pkg.sv
// Shared constants and types for the FT232H 245-style synchronous FIFO emulator.
package ft232h_pkg;
    localparam int USB_DATA_W       = 8;
    localparam int DEFAULT_DEPTH    = 512;
    localparam int ERR_W            = 3;
    localparam int ERR_RD_UNDERRUN  = 0;
    localparam int ERR_WR_OVERRUN   = 1;
    localparam int ERR_BUS_CONFLICT = 2;

    typedef logic [USB_DATA_W-1:0] usb_byte_t;
endpackage

// File: rtl/ft232h_fifo_emu_if.sv
// FT232H parallel bus as seen between an FPGA-side controller (master) and the emulator (slave).
interface ft232h_fifo_emu_if;
    import ft232h_pkg::*;

    logic      usb_rxf_n;
    logic      usb_txe_n;
    logic      usb_oe_n;
    logic      usb_rd_n;
    logic      usb_wr_n;
    logic      usb_data_oe;
    usb_byte_t usb_data_in;
    usb_byte_t usb_data_out;

    modport master (
        input  usb_rxf_n, usb_txe_n, usb_data_out, usb_data_oe,
        output usb_oe_n, usb_rd_n, usb_wr_n, usb_data_in
    );

    modport slave (
        output usb_rxf_n, usb_txe_n, usb_data_out, usb_data_oe,
        input  usb_oe_n, usb_rd_n, usb_wr_n, usb_data_in
    );
endinterface

// File: rtl/ft232h_fifo_emu_sync_fifo.sv
// Single-clock show-ahead byte FIFO; caller guarantees no push when full and no pop when empty.
module sync_fifo
    import ft232h_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  usb_byte_t        din,
    output usb_byte_t        dout,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);
    localparam int AW = $clog2(DEPTH);

    usb_byte_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/ft232h_fifo_emu.sv
// FT232H synchronous FIFO emulator: RX/TX byte buffers behind registered RXF#/TXE# status,
// with packet-boundary gaps on RXF# and sticky protocol-error flags.
module ft232h_fifo_emu
    import ft232h_pkg::*;
#(
    parameter int  DEPTH     = DEFAULT_DEPTH,
    parameter int  PKT_BYTES = 512,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                   usb_clk_60m,
    input  logic                   sys_rst,
    ft232h_fifo_emu_if.slave       usb,
    input  usb_byte_t              host_rx_data,
    input  logic                   host_rx_valid,
    output logic                   host_rx_ready,
    output usb_byte_t              host_tx_data,
    output logic                   host_tx_valid,
    input  logic                   host_tx_ready,
    output logic [LVL_W-1:0]       rx_level,
    output logic [LVL_W-1:0]       tx_level,
    output logic [ERR_W-1:0]       err_flags
);
    localparam int PKT_W = $clog2(PKT_BYTES + 1) + 1;

    logic             rd_req;
    logic             rx_push;
    logic             rx_pop;
    logic             tx_push;
    logic             tx_pop;
    logic             rd_underrun;
    logic             wr_overrun;
    logic             bus_conflict;
    logic             gap;
    logic [LVL_W-1:0] rx_count_next;
    logic [LVL_W-1:0] tx_count_next;
    logic [PKT_W-1:0] pkt_cnt;
    logic [ERR_W-1:0] err_next;
    usb_byte_t        rx_head;
    usb_byte_t        tx_head;

    always_comb begin
        rd_req       = !usb.usb_rd_n && !usb.usb_oe_n;
        rx_pop       = rd_req && !usb.usb_rxf_n;
        rd_underrun  = rd_req && usb.usb_rxf_n;
        bus_conflict = !usb.usb_oe_n && !usb.usb_wr_n;
        wr_overrun   = !usb.usb_wr_n && usb.usb_txe_n;
        tx_push      = !usb.usb_wr_n && !usb.usb_txe_n && usb.usb_oe_n;
        rx_push      = host_rx_valid && host_rx_ready;
        tx_pop       = host_tx_valid && host_tx_ready;
        gap          = (PKT_BYTES != 0) && rx_pop && (pkt_cnt == PKT_W'(PKT_BYTES - 1));

        err_next                   = err_flags;
        err_next[ERR_RD_UNDERRUN]  = err_flags[ERR_RD_UNDERRUN] | rd_underrun;
        err_next[ERR_WR_OVERRUN]   = err_flags[ERR_WR_OVERRUN] | wr_overrun;
        err_next[ERR_BUS_CONFLICT] = err_flags[ERR_BUS_CONFLICT] | bus_conflict;
    end

    sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk        (usb_clk_60m),
        .rst        (sys_rst),
        .push       (rx_push),
        .pop        (rx_pop),
        .din        (host_rx_data),
        .dout       (rx_head),
        .count      (rx_level),
        .count_next (rx_count_next)
    );

    sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk        (usb_clk_60m),
        .rst        (sys_rst),
        .push       (tx_push),
        .pop        (tx_pop),
        .din        (usb.usb_data_in),
        .dout       (tx_head),
        .count      (tx_level),
        .count_next (tx_count_next)
    );

    // The head of an empty buffer is stale memory, so present zero instead.
    assign usb.usb_data_out = (rx_level != '0) ? rx_head : '0;
    assign host_tx_data     = (tx_level != '0) ? tx_head : '0;

    // host_tx_valid needs both the old and new count non-zero: it rises one
    // cycle after the first push but falls on the very edge that empties the buffer.
    always_ff @(posedge usb_clk_60m) begin
        if (sys_rst) begin
            usb.usb_rxf_n   <= 1'b1;
            usb.usb_txe_n   <= 1'b1;
            usb.usb_data_oe <= 1'b0;
            host_rx_ready   <= 1'b0;
            host_tx_valid   <= 1'b0;
            pkt_cnt         <= '0;
            err_flags       <= '0;
        end else begin
            usb.usb_rxf_n   <= (rx_count_next == '0) || gap;
            usb.usb_txe_n   <= (tx_count_next == LVL_W'(DEPTH));
            usb.usb_data_oe <= !usb.usb_oe_n;
            host_rx_ready   <= (rx_count_next != LVL_W'(DEPTH));
            host_tx_valid   <= (tx_count_next != '0) && (tx_level != '0);
            pkt_cnt         <= (gap || rx_count_next == '0) ? '0 : pkt_cnt + PKT_W'(rx_pop);
            err_flags       <= err_next;
        end
    end
endmodule

// File: tb/tb_ft232h_fifo_emu.sv
// Directed bench: DUT a (DEPTH=512, no packet gap) and DUT b (DEPTH=16, PKT_BYTES=4).
module tb_ft232h_fifo_emu;
    import ft232h_pkg::*;

    localparam int LVL_A = $clog2(512) + 1;
    localparam int LVL_B = $clog2(16) + 1;

    logic usb_clk_60m = 1'b0;
    logic sys_rst     = 1'b1;
    always #8 usb_clk_60m = ~usb_clk_60m;

    ft232h_fifo_emu_if bus_a ();
    ft232h_fifo_emu_if bus_b ();

    usb_byte_t        host_rx_data_a, host_tx_data_a, host_rx_data_b, host_tx_data_b;
    logic             host_rx_valid_a, host_rx_ready_a, host_tx_valid_a, host_tx_ready_a;
    logic             host_rx_valid_b, host_rx_ready_b, host_tx_valid_b, host_tx_ready_b;
    logic [LVL_A-1:0] rx_level_a, tx_level_a;
    logic [LVL_B-1:0] rx_level_b, tx_level_b;
    logic [2:0]       err_flags_a, err_flags_b;

    ft232h_fifo_emu #(.DEPTH(512), .PKT_BYTES(0)) dut_a (
        .usb_clk_60m   (usb_clk_60m),
        .sys_rst       (sys_rst),
        .usb           (bus_a),
        .host_rx_data  (host_rx_data_a),
        .host_rx_valid (host_rx_valid_a),
        .host_rx_ready (host_rx_ready_a),
        .host_tx_data  (host_tx_data_a),
        .host_tx_valid (host_tx_valid_a),
        .host_tx_ready (host_tx_ready_a),
        .rx_level      (rx_level_a),
        .tx_level      (tx_level_a),
        .err_flags     (err_flags_a)
    );

    ft232h_fifo_emu #(.DEPTH(16), .PKT_BYTES(4)) dut_b (
        .usb_clk_60m   (usb_clk_60m),
        .sys_rst       (sys_rst),
        .usb           (bus_b),
        .host_rx_data  (host_rx_data_b),
        .host_rx_valid (host_rx_valid_b),
        .host_rx_ready (host_rx_ready_b),
        .host_tx_data  (host_tx_data_b),
        .host_tx_valid (host_tx_valid_b),
        .host_tx_ready (host_tx_ready_b),
        .rx_level      (rx_level_b),
        .tx_level      (tx_level_b),
        .err_flags     (err_flags_b)
    );

    int        checks   = 0;
    int        failures = 0;
    int        rd_cnt;
    usb_byte_t rd_buf [0:127];

    task automatic idle_inputs;
        bus_a.usb_oe_n = 1'b1; bus_a.usb_rd_n = 1'b1; bus_a.usb_wr_n = 1'b1; bus_a.usb_data_in = '0;
        bus_b.usb_oe_n = 1'b1; bus_b.usb_rd_n = 1'b1; bus_b.usb_wr_n = 1'b1; bus_b.usb_data_in = '0;
        host_rx_valid_a = 1'b0; host_rx_data_a = '0; host_tx_ready_a = 1'b0;
        host_rx_valid_b = 1'b0; host_rx_data_b = '0; host_tx_ready_b = 1'b0;
    endtask

    task automatic do_reset;
        sys_rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge usb_clk_60m);
        sys_rst = 1'b0;
        rd_cnt  = 0;
    endtask

    task automatic push_a(input int n, input int base);
        int   k = 0;
        logic acc;
        for (int c = 0; c < n + 20 && k < n; c++) begin
            host_rx_valid_a = 1'b1;
            host_rx_data_a  = 8'(base + k);
            acc = host_rx_ready_a;
            @(negedge usb_clk_60m);
            if (acc) k++;
        end
        host_rx_valid_a = 1'b0;
    endtask

    task automatic push_b(input int n, input int base);
        int   k = 0;
        logic acc;
        for (int c = 0; c < n + 20 && k < n; c++) begin
            host_rx_valid_b = 1'b1;
            host_rx_data_b  = 8'(base + k);
            acc = host_rx_ready_b;
            @(negedge usb_clk_60m);
            if (acc) k++;
        end
        host_rx_valid_b = 1'b0;
    endtask

    // Controller model: assert rd_n only while RXF# is low; capture the byte popped on the next edge.
    task automatic read_a(input int n);
        int target = rd_cnt + n;
        for (int c = 0; c < 4 * n + 20; c++) begin
            if (rd_cnt == target) break;
            bus_a.usb_rd_n = bus_a.usb_rxf_n;
            if (!bus_a.usb_rd_n) begin
                rd_buf[rd_cnt] = bus_a.usb_data_out;
                rd_cnt++;
            end
            @(negedge usb_clk_60m);
        end
        bus_a.usb_rd_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (bus_a.usb_rxf_n !== 1'b1) begin failures++; $display("FAIL rst_rxf_n: got %0b want 1", bus_a.usb_rxf_n); end
        checks++; if (bus_a.usb_txe_n !== 1'b1) begin failures++; $display("FAIL rst_txe_n: got %0b want 1", bus_a.usb_txe_n); end
        checks++; if (bus_a.usb_data_oe !== 1'b0) begin failures++; $display("FAIL rst_data_oe: got %0b want 0", bus_a.usb_data_oe); end
        checks++; if (bus_a.usb_data_out !== 8'h00) begin failures++; $display("FAIL rst_data_out: got %0h want 0", bus_a.usb_data_out); end
        checks++; if ({host_rx_ready_a, host_tx_valid_a} !== 2'b00) begin failures++; $display("FAIL rst_host_hs: got %0b want 00", {host_rx_ready_a, host_tx_valid_a}); end
        checks++; if ({rx_level_a, tx_level_a, err_flags_a} !== '0) begin failures++; $display("FAIL rst_levels_err: got %0h %0h %0h want 0", rx_level_a, tx_level_a, err_flags_a); end
        @(negedge usb_clk_60m);
        checks++; if (host_rx_ready_a !== 1'b1) begin failures++; $display("FAIL post_rst_rx_ready: got %0b want 1", host_rx_ready_a); end
        checks++; if ({bus_a.usb_txe_n, bus_a.usb_rxf_n, host_tx_valid_a} !== 3'b010) begin failures++; $display("FAIL post_rst_status: got %0b want 010", {bus_a.usb_txe_n, bus_a.usb_rxf_n, host_tx_valid_a}); end
    endtask

    task automatic test_stream_read;
        int bad = 0;
        do_reset();
        @(negedge usb_clk_60m);
        push_a(1, 1);
        checks++; if (bus_a.usb_rxf_n !== 1'b0) begin failures++; $display("FAIL rxf_after_first_push: got %0b want 0", bus_a.usb_rxf_n); end
        push_a(99, 2);
        checks++; if (rx_level_a !== LVL_A'(100)) begin failures++; $display("FAIL stream_rx_level: got %0d want 100", rx_level_a); end
        bus_a.usb_oe_n = 1'b0;
        checks++; if (bus_a.usb_data_oe !== 1'b0) begin failures++; $display("FAIL oe_before_edge: got %0b want 0", bus_a.usb_data_oe); end
        @(negedge usb_clk_60m);
        checks++; if (bus_a.usb_data_oe !== 1'b1) begin failures++; $display("FAIL oe_after_edge: got %0b want 1", bus_a.usb_data_oe); end
        read_a(100);
        checks++; if (rd_cnt !== 100) begin failures++; $display("FAIL stream_count: got %0d want 100", rd_cnt); end
        for (int i = 0; i < 100; i++) if (rd_buf[i] !== 8'(i + 1)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL stream_order: got %0d bad bytes want 0", bad); end
        checks++; if ({bus_a.usb_rxf_n, rx_level_a, err_flags_a} !== {1'b1, LVL_A'(0), 3'b000}) begin failures++; $display("FAIL stream_end: got rxf=%0b lvl=%0d err=%0b want 1 0 0", bus_a.usb_rxf_n, rx_level_a, err_flags_a); end
        bus_a.usb_oe_n = 1'b1;
    endtask

    task automatic test_packet_gap;
        int        got = 0, gaps = 0, g0 = -1, g1 = -1, bad = 0;
        usb_byte_t buf_b [0:15];
        do_reset();
        @(negedge usb_clk_60m);
        push_b(10, 8'hA0);
        bus_b.usb_oe_n = 1'b0;
        @(negedge usb_clk_60m);
        for (int c = 0; c < 60; c++) begin
            if (got == 10) break;
            bus_b.usb_rd_n = bus_b.usb_rxf_n;
            if (!bus_b.usb_rd_n) begin
                buf_b[got] = bus_b.usb_data_out;
                got++;
            end else if (got > 0) begin
                if (gaps == 0) g0 = got; else if (gaps == 1) g1 = got;
                gaps++;
            end
            @(negedge usb_clk_60m);
        end
        bus_b.usb_rd_n = 1'b1;
        bus_b.usb_oe_n = 1'b1;
        for (int i = 0; i < 10; i++) if (buf_b[i] !== 8'(8'hA0 + i)) bad++;
        checks++; if (got !== 10) begin failures++; $display("FAIL gap_count: got %0d want 10", got); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL gap_order: got %0d bad bytes want 0", bad); end
        checks++; if (gaps !== 2) begin failures++; $display("FAIL gap_cycles: got %0d want 2", gaps); end
        checks++; if ({g0, g1} !== {32'sd4, 32'sd8}) begin failures++; $display("FAIL gap_position: got %0d,%0d want 4,8", g0, g1); end
        checks++; if (err_flags_b !== 3'b000) begin failures++; $display("FAIL gap_err: got %0b want 000", err_flags_b); end
    endtask

    task automatic test_tx_overrun;
        int        got = 0, bad = 0;
        usb_byte_t buf_t [0:31];
        do_reset();
        @(negedge usb_clk_60m);
        for (int i = 0; i < 20; i++) begin
            bus_b.usb_wr_n    = 1'b0;
            bus_b.usb_data_in = 8'(i + 1);
            @(negedge usb_clk_60m);
        end
        bus_b.usb_wr_n = 1'b1;
        checks++; if (bus_b.usb_txe_n !== 1'b1) begin failures++; $display("FAIL tx_full_txe: got %0b want 1", bus_b.usb_txe_n); end
        checks++; if (tx_level_b !== LVL_B'(16)) begin failures++; $display("FAIL tx_full_level: got %0d want 16", tx_level_b); end
        checks++; if (err_flags_b !== 3'b010) begin failures++; $display("FAIL tx_overrun_err: got %0b want 010", err_flags_b); end
        host_tx_ready_b = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (host_tx_valid_b && got < 32) begin
                buf_t[got] = host_tx_data_b;
                got++;
            end
            @(negedge usb_clk_60m);
        end
        host_tx_ready_b = 1'b0;
        for (int i = 0; i < 16; i++) if (buf_t[i] !== 8'(i + 1)) bad++;
        checks++; if (got !== 16) begin failures++; $display("FAIL tx_drain_count: got %0d want 16", got); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL tx_drain_order: got %0d bad bytes want 0", bad); end
        checks++; if ({tx_level_b, bus_b.usb_txe_n} !== {LVL_B'(0), 1'b0}) begin failures++; $display("FAIL tx_drained: got lvl=%0d txe=%0b want 0 0", tx_level_b, bus_b.usb_txe_n); end
    endtask

    task automatic test_errors;
        do_reset();
        @(negedge usb_clk_60m);
        bus_b.usb_oe_n = 1'b0;
        bus_b.usb_rd_n = 1'b0;
        repeat (3) @(negedge usb_clk_60m);
        checks++; if (err_flags_b !== 3'b001) begin failures++; $display("FAIL underrun_err: got %0b want 001", err_flags_b); end
        checks++; if ({rx_level_b, bus_b.usb_rxf_n} !== {LVL_B'(0), 1'b1}) begin failures++; $display("FAIL underrun_level: got lvl=%0d rxf=%0b want 0 1", rx_level_b, bus_b.usb_rxf_n); end
        bus_b.usb_rd_n    = 1'b1;
        bus_b.usb_wr_n    = 1'b0;
        bus_b.usb_data_in = 8'h5A;
        @(negedge usb_clk_60m);
        bus_b.usb_wr_n = 1'b1;
        bus_b.usb_oe_n = 1'b1;
        @(negedge usb_clk_60m);
        checks++; if (err_flags_b !== 3'b101) begin failures++; $display("FAIL conflict_err: got %0b want 101", err_flags_b); end
        checks++; if ({tx_level_b, host_tx_valid_b} !== {LVL_B'(0), 1'b0}) begin failures++; $display("FAIL conflict_no_push: got lvl=%0d vld=%0b want 0 0", tx_level_b, host_tx_valid_b); end
    endtask

    task automatic test_back_to_back;
        int   pushed = 3, lvl_bad = 0, bad = 0;
        logic acc;
        do_reset();
        @(negedge usb_clk_60m);
        push_a(3, 0);
        bus_a.usb_oe_n = 1'b0;
        @(negedge usb_clk_60m);
        for (int c = 0; c < 50; c++) begin
            if (rx_level_a !== LVL_A'(3)) lvl_bad++;
            host_rx_valid_a = 1'b1;
            host_rx_data_a  = 8'(pushed);
            acc = host_rx_ready_a;
            bus_a.usb_rd_n  = bus_a.usb_rxf_n;
            if (!bus_a.usb_rd_n) begin
                rd_buf[rd_cnt] = bus_a.usb_data_out;
                rd_cnt++;
            end
            @(negedge usb_clk_60m);
            if (acc) pushed++;
        end
        host_rx_valid_a = 1'b0;
        checks++; if (lvl_bad !== 0) begin failures++; $display("FAIL b2b_level: got %0d off-level cycles want 0", lvl_bad); end
        read_a(3);
        for (int i = 0; i < 53; i++) if (rd_buf[i] !== 8'(i)) bad++;
        checks++; if ({rd_cnt, pushed} !== {32'sd53, 32'sd53}) begin failures++; $display("FAIL b2b_count: got read=%0d pushed=%0d want 53 53", rd_cnt, pushed); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_order: got %0d bad bytes want 0", bad); end
        checks++; if ({bus_a.usb_rxf_n, err_flags_a} !== 4'b1000) begin failures++; $display("FAIL b2b_end: got rxf=%0b err=%0b want 1 000", bus_a.usb_rxf_n, err_flags_a); end
        bus_a.usb_oe_n = 1'b1;
    endtask

    task automatic test_reset_midburst;
        do_reset();
        @(negedge usb_clk_60m);
        push_a(10, 8'h30);
        bus_a.usb_oe_n = 1'b0;
        @(negedge usb_clk_60m);
        read_a(3);
        bus_a.usb_rd_n  = 1'b0;
        host_rx_valid_a = 1'b1;
        sys_rst         = 1'b1;
        @(negedge usb_clk_60m);
        checks++; if ({bus_a.usb_rxf_n, bus_a.usb_txe_n, bus_a.usb_data_oe} !== 3'b110) begin failures++; $display("FAIL midrst_status: got %0b want 110", {bus_a.usb_rxf_n, bus_a.usb_txe_n, bus_a.usb_data_oe}); end
        checks++; if ({rx_level_a, tx_level_a, err_flags_a, bus_a.usb_data_out} !== '0) begin failures++; $display("FAIL midrst_state: got lvl=%0d/%0d err=%0b out=%0h want 0", rx_level_a, tx_level_a, err_flags_a, bus_a.usb_data_out); end
        checks++; if ({host_rx_ready_a, host_tx_valid_a} !== 2'b00) begin failures++; $display("FAIL midrst_host: got %0b want 00", {host_rx_ready_a, host_tx_valid_a}); end
        sys_rst         = 1'b0;
        bus_a.usb_rd_n  = 1'b1;
        bus_a.usb_oe_n  = 1'b1;
        host_rx_valid_a = 1'b0;
        rd_cnt          = 0;
        @(negedge usb_clk_60m);
        push_a(2, 8'h55);
        bus_a.usb_oe_n = 1'b0;
        @(negedge usb_clk_60m);
        read_a(2);
        bus_a.usb_oe_n = 1'b1;
        checks++; if ({rd_cnt[7:0], rd_buf[0], rd_buf[1]} !== {8'd2, 8'h55, 8'h56}) begin failures++; $display("FAIL midrst_resume: got n=%0d %0h %0h want 2 55 56", rd_cnt, rd_buf[0], rd_buf[1]); end
        checks++; if (err_flags_a !== 3'b000) begin failures++; $display("FAIL midrst_resume_err: got %0b want 000", err_flags_a); end
    endtask

    initial begin
        idle_inputs();
        rd_cnt = 0;
        @(negedge usb_clk_60m);
        test_reset();
        test_stream_read();
        test_packet_gap();
        test_tx_overrun();
        test_errors();
        test_back_to_back();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ft232h_fifo_emu.md
# ft232h_fifo_emu

Synthesizable chip-side emulator of the FT232H 245-style synchronous FIFO interface, clocked by the 60 MHz USB clock. It lets FPGA-side USB controllers run in hardware loopback and on-board self-test without the physical FT232H. It presents RXF#/TXE# status and the data bus to the controller and buffers bytes in two internal FIFOs. A byte-stream port on the far side injects host→FPGA bytes and drains FPGA→host bytes.

## Interface
- DEPTH, 512: entries per direction buffer (power of two, ≥4).
- PKT_BYTES, 512: after this many consecutive reads, RXF# is forced high for one cycle to emulate a USB packet boundary. 0 disables the gap.
- LVL_W, $clog2(DEPTH)+1: level counter width (derived, not overridden).

Ports (all sampled or driven on the rising edge of usb_clk_60m):
- usb_clk_60m  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- usb_rxf_n  out  1  low = RX buffer has a byte the controller may read.
- usb_txe_n  out  1  low = TX buffer can accept a byte.
- usb_oe_n  in  1  controller output enable; low requests the emulator to drive the bus.
- usb_rd_n  in  1  controller read strobe.
- usb_wr_n  in  1  controller write strobe.
- usb_data_in  in  8  bus value driven by the controller.
- usb_data_out  out  8  bus value driven by the emulator.
- usb_data_oe  out  1  emulator drive enable; the top level builds the tristate.
- host_rx_data  in  8  byte to send toward the controller.
- host_rx_valid  in  1  host_rx_data valid.
- host_rx_ready  out  1  RX buffer not full.
- host_tx_data  out  8  byte written by the controller.
- host_tx_valid  out  1  TX buffer not empty.
- host_tx_ready  in  1  host consumes host_tx_data.
- rx_level, tx_level  out  LVL_W  buffer occupancy.
- err_flags  out  3  sticky error bits: [0] read underrun, [1] write overrun, [2] bus conflict.

## Operation
- Reset values: usb_rxf_n=1, usb_txe_n=1, usb_data_oe=0, usb_data_out=0, host_tx_valid=0, host_rx_ready=0, levels=0, err_flags=0, packet counter=0. Both buffers are flushed.
- host_rx_ready and host_tx_valid are registered. Each is valid on the first cycle after reset release.
- RX path:
  - A host push occurs when host_rx_valid && host_rx_ready.
  - usb_data_out always shows the RX head (show-ahead).
  - A USB pop occurs on an edge where usb_rd_n=0, usb_oe_n=0 and usb_rxf_n=0.
- usb_rxf_n is registered. Its next value is (rx_count_next==0) || gap. gap is asserted for exactly one cycle when the pop count reaches PKT_BYTES; the packet counter then clears. The packet counter also clears when rx_count_next==0.
- usb_data_oe is registered as !usb_oe_n, giving one cycle of bus turnaround.
- TX path:
  - A USB push occurs on an edge where usb_wr_n=0, usb_txe_n=0 and usb_oe_n=1; the byte stored is usb_data_in.
  - usb_txe_n is registered. Its next value is (tx_count_next==DEPTH).
  - A host pop occurs when host_tx_valid && host_tx_ready.
- Simultaneous push and pop on the same buffer: the level is unchanged and both transfers take effect. This holds for a full buffer and an empty buffer alike: an empty-buffer push-and-pop cannot occur because the pop requires a non-empty registered status.
- Error flags:
  - err[0] sets when usb_rd_n=0 && usb_oe_n=0 && usb_rxf_n=1. No pop occurs.
  - err[1] sets when usb_wr_n=0 && usb_txe_n=1. The byte is dropped.
  - err[2] sets when usb_oe_n=0 && usb_wr_n=0. No push occurs.
  - All flags clear only on sys_rst.
- Pointers wrap modulo DEPTH. Levels saturate naturally in the 0..DEPTH range.

## Timing
- Host push accepted at edge N: usb_rxf_n is low after edge N (first read possible at edge N+1).
- usb_oe_n low sampled at edge N: usb_data_oe=1 after edge N. The controller asserts usb_rd_n no earlier than edge N+1.
- During a continuous read, one byte is popped per edge. usb_data_out advances after each pop edge.
- When the last byte is popped at edge N, usb_rxf_n=1 after edge N. A usb_rd_n held low afterwards sets err[0].
- A USB push at edge N makes host_tx_valid=1 after edge N+1 (one-cycle registered status).
- Reset asserted mid-burst: all outputs take their reset values after the next edge, regardless of strobes.

## Structure
- Package ft232h_pkg holds USB_DATA_W=8, DEFAULT_DEPTH=512, and the error-bit indices ERR_RD_UNDERRUN=0, ERR_WR_OVERRUN=1, ERR_BUS_CONFLICT=2.
- Sub-module sync_fifo (single clock, show-ahead, exposes count_next) is instantiated twice, once for RX and once for TX.
- The top level holds the strobe qualification, the packet-gap counter, the error logic and the registered bus status.

## Test plan
- Push bytes 1..100 from the host with PKT_BYTES=0, then hold oe_n and rd_n low continuously → controller reads 1..100 in order, rxf_n=1 after the 100th pop, err_flags=0.
- PKT_BYTES=4 with 10 bytes queued and continuous reads → rxf_n high for exactly one cycle after bytes 4 and 8; all 10 bytes are delivered with no loss.
- DEPTH=16: the controller writes 20 bytes with wr_n held low and host_tx_ready=0 → txe_n=1 after the 16th write, 4 writes dropped, err[1]=1, tx_level=16; then raise host_tx_ready → bytes 1..16 drain.
- Hold rd_n and oe_n low with an empty RX buffer → err[0]=1, rx_level stays 0. Then drive oe_n=0 and wr_n=0 together → err[2]=1 and no TX push occurs.
- Host pushes while the controller reads simultaneously, with rx_level=3 for 50 cycles → the level stays at 3 and the data order is preserved.
- Assert sys_rst mid-read-burst → rxf_n=1, txe_n=1, usb_data_oe=0, levels=0, err_flags=0 after the next edge; normal operation resumes afterwards.
